hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 23 ++
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard_stage.sv | 29 ++
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: shadow-pipe entry layout, sizes and
// the bubble constant.
package hazard_scoreboard_pkg;

  localparam int NREG   = 8;
  localparam int AW     = 3;
  localparam int CNT_W  = 16;
  localparam int NSTAGE = 3;  // EXE, MEM, WB

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          we;
    logic          load;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, rd: '0, we: 1'b0, load: 1'b0};

  function automatic logic writes_reg(input stage_t s, input logic [AW-1:0] r);
    return s.valid & s.we & (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and pipeline-control bundle between the core and the
// hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG  = hazard_scoreboard_pkg::NREG,
  parameter int AW    = hazard_scoreboard_pkg::AW,
  parameter int CNT_W = hazard_scoreboard_pkg::CNT_W
);

  logic             id_valid;
  logic [AW-1:0]    Rs_id;
  logic [AW-1:0]    Rd_id;
  logic             rs_used_id;
  logic             rd_used_id;
  logic             reg_write_id;
  logic             mem_read_id;
  logic             flush;
  logic             stall;
  logic             pc_write;
  logic             ifid_write;
  logic             bubble_exe;
  logic [NREG-1:0]  busy_mask;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, Rs_id, Rd_id, rs_used_id, rd_used_id,
           reg_write_id, mem_read_id, flush,
    input  stall, pc_write, ifid_write, bubble_exe, busy_mask, stall_count
  );

  modport slave (
    input  id_valid, Rs_id, Rd_id, rs_used_id, rd_used_id,
           reg_write_id, mem_read_id, flush,
    output stall, pc_write, ifid_write, bubble_exe, busy_mask, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_stage.sv
// One shadow-pipe entry: a registered stage_t that loads a bubble when killed.
module scoreboard_stage
  import hazard_scoreboard_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   kill_i,
  input  stage_t entry_i,
  output stage_t entry_o
);

  stage_t entry_q;
  stage_t entry_d;

  always_comb begin
    entry_d = kill_i ? BUBBLE : entry_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detector: shadows EXE/MEM/WB destinations, stalls one cycle
// on a load-use dependency, applies branch flush and counts stall cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG  = hazard_scoreboard_pkg::NREG,
  parameter int AW    = hazard_scoreboard_pkg::AW,
  parameter int CNT_W = hazard_scoreboard_pkg::CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);

  stage_t            pipe_q [NSTAGE];
  stage_t            pipe_d [NSTAGE];
  logic [NSTAGE-1:0] kill;
  stage_t            exe;
  logic              operand_hit;
  logic              stall_c;
  logic              issue;
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign exe = pipe_q[0];

  // Only a load in EXE stalls; ALU results reach the consumer by forwarding.
  always_comb begin
    operand_hit = (sb.rs_used_id & (sb.Rs_id == exe.rd)) |
                  (sb.rd_used_id & (sb.Rd_id == exe.rd));
    stall_c     = rst_n & sb.id_valid & exe.valid & exe.we & exe.load &
                  operand_hit & ~sb.flush;
    issue       = sb.id_valid & ~stall_c & ~sb.flush;
  end

  always_comb begin
    pipe_d[0] = BUBBLE;
    if (issue) begin
      pipe_d[0].valid = 1'b1;
      pipe_d[0].rd    = sb.Rd_id;
      pipe_d[0].we    = sb.reg_write_id;
      pipe_d[0].load  = sb.mem_read_id;
    end
    pipe_d[1] = pipe_q[0];
    pipe_d[2] = pipe_q[1];
    kill      = '0;
    kill[1]   = sb.flush;  // the taken branch's shadow in EXE must not reach MEM
  end

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
    scoreboard_stage u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .kill_i  (kill[gi]),
      .entry_i (pipe_d[gi]),
      .entry_o (pipe_q[gi])
    );
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    localparam logic [AW-1:0] IDX = AW'(gi);
    logic hit;
    always_comb begin
      hit = 1'b0;
      for (int s = 0; s < NSTAGE; s++) begin
        hit = hit | writes_reg(pipe_q[s], IDX);
      end
    end
    assign busy[gi] = rst_n & hit;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sb.stall       = stall_c;
  assign sb.pc_write    = ~stall_c;
  assign sb.ifid_write  = ~stall_c;
  assign sb.bubble_exe  = rst_n & (stall_c | sb.flush);
  assign sb.busy_mask   = busy;
  assign sb.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: stimulus pushes expected outputs, a negedge
// monitor pops and compares. A 2-bit-counter twin checks saturation.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(8), .AW(3), .CNT_W(16)) bus  ();
  hazard_scoreboard_if #(.NREG(8), .AW(3), .CNT_W(2))  bus2 ();

  hazard_scoreboard #(.NREG(8), .AW(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sb(bus)
  );
  hazard_scoreboard #(.NREG(8), .AW(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sb(bus2)
  );

  // ctl = {stall, pc_write, ifid_write, bubble_exe}
  localparam logic [3:0] N = 4'b0110;
  localparam logic [3:0] S = 4'b1001;
  localparam logic [3:0] F = 4'b0111;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [7:0]  bm;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t expq[$];
  exp_t m;
  int   total = 0;
  int   bad   = 0;

  task automatic step(input string nm, input logic rn, input logic v,
                      input logic [2:0] rs, input logic rsu,
                      input logic [2:0] rd, input logic rdu,
                      input logic we, input logic ld, input logic fl,
                      input logic [3:0] ctl, input logic [7:0] bm,
                      input logic [15:0] cnt, input logic drop_rst);
    exp_t e;
    rst_n             = rn;
    bus.id_valid      = v;    bus2.id_valid     = v;
    bus.Rs_id         = rs;   bus2.Rs_id        = rs;
    bus.rs_used_id    = rsu;  bus2.rs_used_id   = rsu;
    bus.Rd_id         = rd;   bus2.Rd_id        = rd;
    bus.rd_used_id    = rdu;  bus2.rd_used_id   = rdu;
    bus.reg_write_id  = we;   bus2.reg_write_id = we;
    bus.mem_read_id   = ld;   bus2.mem_read_id  = ld;
    bus.flush         = fl;   bus2.flush        = fl;
    e.name = nm;
    e.ctl  = ctl;
    e.bm   = bm;
    e.cnt  = cnt;
    e.cnt2 = (cnt > 16'd3) ? 2'd3 : cnt[1:0];
    expq.push_back(e);
    if (drop_rst) begin
      @(negedge clk);
      #1 rst_n = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic [7:0] bm, input logic [15:0] cnt);
    step(nm, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, N, bm, cnt, 1'b0);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      m = expq.pop_front();
      total++;
      if ({bus.stall, bus.pc_write, bus.ifid_write, bus.bubble_exe,
           bus.busy_mask, bus.stall_count, bus2.stall_count} !==
          {m.ctl, m.bm, m.cnt, m.cnt2}) begin
        bad++;
        $display("FAIL %s: got ctl=%b busy=%h cnt=%h sat=%0d, want ctl=%b busy=%h cnt=%h sat=%0d",
                 m.name, {bus.stall, bus.pc_write, bus.ifid_write, bus.bubble_exe},
                 bus.busy_mask, bus.stall_count, bus2.stall_count,
                 m.ctl, m.bm, m.cnt, m.cnt2);
      end else begin
        $display("ok   %s: ctl=%b busy=%h cnt=%0d sat=%0d",
                 m.name, m.ctl, m.bm, m.cnt, m.cnt2);
      end
    end
  end

  initial begin
    step("pre_reset", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, N, 8'h00, 16'd0, 1'b0);
    expq.delete();
    @(posedge clk); #1;
    // reset holds outputs quiet even with a load presented in ID
    step("reset_hold",  1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd0, 1'b0);

    // load r3 then Rs=3 consumer: one stall, then issue
    step("t1_load_r3",  1'b1, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd0, 1'b0);
    step("t1_use_stall",1'b1, 1'b1, 3'd3, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, S, 8'h08, 16'd0, 1'b0);
    step("t1_use_issue",1'b1, 1'b1, 3'd3, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, N, 8'h08, 16'd1, 1'b0);
    idle("t1_drain0", 8'h18, 16'd1);
    idle("t1_drain1", 8'h10, 16'd1);
    idle("t1_drain2", 8'h10, 16'd1);
    idle("t1_drain3", 8'h00, 16'd1);

    // ALU producer: never stalls, busy for three cycles
    step("t2_alu_r3",     1'b1, 1'b1, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, N, 8'h00, 16'd1, 1'b0);
    step("t2_use_nostall",1'b1, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, N, 8'h08, 16'd1, 1'b0);
    idle("t2_drain0", 8'h08, 16'd1);
    idle("t2_drain1", 8'h08, 16'd1);
    idle("t2_drain2", 8'h00, 16'd1);

    // flush overrides the load-use stall and kills the load
    step("t3_load_r5",  1'b1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd1, 1'b0);
    step("t3_use_flush",1'b1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, F, 8'h20, 16'd1, 1'b0);
    idle("t3_after0", 8'h00, 16'd1);
    idle("t3_after1", 8'h00, 16'd1);

    // Rd-operand dependency without flush stalls
    step("t3b_load_r5", 1'b1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd1, 1'b0);
    step("t3b_rd_stall",1'b1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, S, 8'h20, 16'd1, 1'b0);
    step("t3b_rd_issue",1'b1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, N, 8'h20, 16'd2, 1'b0);
    idle("t3b_drain0", 8'h20, 16'd2);
    idle("t3b_drain1", 8'h20, 16'd2);
    idle("t3b_drain2", 8'h20, 16'd2);
    idle("t3b_drain3", 8'h00, 16'd2);

    // back-to-back loads r1, r2 then Rs=2 consumer
    step("t4_load_r1",  1'b1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd2, 1'b0);
    step("t4_load_r2",  1'b1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h02, 16'd2, 1'b0);
    step("t4_use_stall",1'b1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, S, 8'h06, 16'd2, 1'b0);
    step("t4_use_issue",1'b1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, N, 8'h06, 16'd3, 1'b0);
    idle("t4_drain0", 8'h0C, 16'd3);
    idle("t4_drain1", 8'h08, 16'd3);
    idle("t4_drain2", 8'h08, 16'd3);
    idle("t4_drain3", 8'h00, 16'd3);

    // index 0 is ordinary; unused Rs never stalls
    step("t5_load_r0",   1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd3, 1'b0);
    step("t5_rs_unused", 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, N, 8'h01, 16'd3, 1'b0);
    idle("t5_drain0", 8'h01, 16'd3);
    idle("t5_drain1", 8'h01, 16'd3);
    idle("t5_drain2", 8'h00, 16'd3);
    step("t5_load_r0b",  1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd3, 1'b0);
    step("t5_r0_stall",  1'b1, 1'b1, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, S, 8'h01, 16'd3, 1'b0);
    step("t5_r0_issue",  1'b1, 1'b1, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, N, 8'h01, 16'd4, 1'b0);
    idle("t5_drain3", 8'h01, 16'd4);
    idle("t5_drain4", 8'h00, 16'd4);

    // fifth stall: the 2-bit twin stays pinned at 3
    step("t6_load_r4",  1'b1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd4, 1'b0);
    step("t6_use_stall",1'b1, 1'b1, 3'd4, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, S, 8'h10, 16'd4, 1'b0);
    step("t6_use_issue",1'b1, 1'b1, 3'd4, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, N, 8'h10, 16'd5, 1'b0);
    idle("t6_drain0", 8'h10, 16'd5);
    idle("t6_drain1", 8'h00, 16'd5);

    // reset dropped during a stall cycle aborts it
    step("t7_load_r6",   1'b1, 1'b1, 3'd0, 1'b0, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, N, 8'h00, 16'd5, 1'b0);
    step("t7_stall_rst", 1'b1, 1'b1, 3'd6, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, S, 8'h40, 16'd5, 1'b1);
    step("t7_after_rst", 1'b1, 1'b1, 3'd6, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, N, 8'h00, 16'd0, 1'b0);
    idle("t7_drain0", 8'h80, 16'd0);

    repeat (2) @(posedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
